// File: rtl/elevator_request_scheduler.sv
// Elevator request scheduler: latches floor calls and steers the car with IDLE/UP/DOWN/DOOR sequencing.
// Optional fire recall is compiled in with `define ELEVATOR_FIRE_RECALL_EN; otherwise fire_recall is ignored.
module elevator_request_scheduler #(
  parameter int unsigned DWELL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] btn,
  input  logic [3:0]  cur_floor,
  input  logic        fire_recall,
  output logic [3:0]  floor_req,
  output logic [15:0] pending,
  output logic        door_open,
  output logic        dir_up,
  output logic        busy
);

  localparam int unsigned NF = 16;
  localparam int unsigned FW = 4;
  localparam int unsigned DW = 8;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2,
    S_DOOR = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [NF-1:0]   pending_q, pending_d;
  logic [FW-1:0]   floor_req_q, floor_req_d;
  logic            dir_up_q, dir_up_d;
  logic            door_open_q, door_open_d;
  logic            busy_q, busy_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [1:0]      sync_q;

  logic            run;
  logic            recall;
  logic            recall_act;
  logic [NF-1:0]   clr;
  logic [NF-1:0]   pend_m;
  logic            has_above, has_below;
  logic [FW-1:0]   above_idx, below_idx;
  logic [FW-1:0]   dist_above, dist_below;
  logic            idle_go_up;
  logic            arrive;
  logic            dwell_done;

`ifdef ELEVATOR_FIRE_RECALL_EN
  assign recall = fire_recall;
`else
  logic fire_recall_unused;
  assign fire_recall_unused = fire_recall;
  assign recall = 1'b0;
`endif

  // Reset release is resynchronised; the FSM stays in IDLE until it has propagated.
  assign run        = sync_q[1];
  assign recall_act = recall & run;

  // Clearing the served floor wins over any press at that floor.
  assign clr       = (state_q == S_DOOR) ? (NF'(1) << cur_floor) : '0;
  assign pend_m    = pending_q & ~clr;
  assign pending_d = recall_act ? '0 : ((pending_q | btn) & ~clr);

  // Nearest pending floor strictly above and strictly below the car; no wrap at 0/15.
  always_comb begin
    has_above = 1'b0;
    above_idx = '0;
    has_below = 1'b0;
    below_idx = '0;
    for (int i = int'(NF) - 1; i >= 0; i--) begin
      if (pend_m[i] && (FW'(i) > cur_floor)) begin
        has_above = 1'b1;
        above_idx = FW'(i);
      end
    end
    for (int i = 0; i < int'(NF); i++) begin
      if (pend_m[i] && (FW'(i) < cur_floor)) begin
        has_below = 1'b1;
        below_idx = FW'(i);
      end
    end
  end

  assign dist_above = above_idx - cur_floor;
  assign dist_below = cur_floor - below_idx;
  assign idle_go_up = has_above && (!has_below || (dist_above <= dist_below));
  assign arrive     = (cur_floor == floor_req_q) && pend_m[cur_floor];
  assign dwell_done = (dwell_q == DWELL_LAST);

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      floor_req_q <= '0;
      dir_up_q    <= 1'b1;
      door_open_q <= 1'b0;
      busy_q      <= 1'b0;
      dwell_q     <= '0;
      sync_q      <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      floor_req_q <= floor_req_d;
      dir_up_q    <= dir_up_d;
      door_open_q <= door_open_d;
      busy_q      <= busy_d;
      dwell_q     <= dwell_d;
      sync_q      <= {sync_q[0], 1'b1};
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    if (!run) begin
      state_d = S_IDLE;
    end else if (recall_act) begin
      state_d = (cur_floor == '0) ? S_IDLE : S_DOWN;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pend_m[cur_floor])  state_d = S_DOOR;
          else if (idle_go_up)    state_d = S_UP;
          else if (has_below)     state_d = S_DOWN;
        end
        S_UP: begin
          if (arrive)             state_d = S_DOOR;
          else if (has_above)     state_d = S_UP;
          else if (has_below)     state_d = S_DOWN;
          else                    state_d = S_IDLE;
        end
        S_DOWN: begin
          if (arrive)             state_d = S_DOOR;
          else if (has_below)     state_d = S_DOWN;
          else if (has_above)     state_d = S_UP;
          else                    state_d = S_IDLE;
        end
        S_DOOR: begin
          if (dwell_done) begin
            if (dir_up_q)         state_d = has_above ? S_UP : (has_below ? S_DOWN : S_IDLE);
            else                  state_d = has_below ? S_DOWN : (has_above ? S_UP : S_IDLE);
          end
        end
        default:                  state_d = S_IDLE;
      endcase
    end
  end

  // Output/datapath next values, keyed on the state being entered.
  always_comb begin
    floor_req_d = floor_req_q;
    dir_up_d    = dir_up_q;
    door_open_d = (state_d == S_DOOR);
    busy_d      = (state_d != S_IDLE);
    dwell_d     = '0;
    if (recall_act) begin
      floor_req_d = '0;
      dir_up_d    = 1'b0;
      door_open_d = (cur_floor == '0);
    end else begin
      case (state_d)
        S_IDLE: floor_req_d = cur_floor;
        S_UP: begin
          floor_req_d = above_idx;
          dir_up_d    = 1'b1;
        end
        S_DOWN: begin
          floor_req_d = below_idx;
          dir_up_d    = 1'b0;
        end
        S_DOOR: begin
          floor_req_d = cur_floor;
          dwell_d     = (state_q == S_DOOR) ? (dwell_q + DW'(1)) : '0;
        end
        default: floor_req_d = cur_floor;
      endcase
    end
  end

  assign floor_req = floor_req_q;
  assign pending   = pending_q;
  assign door_open = door_open_q;
  assign dir_up    = dir_up_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench for elevator_request_scheduler: hand-computed expectations per scenario.
// Build with +define+ELEVATOR_FIRE_RECALL_EN to exercise the recall scenario instead of the ignore scenario.
module tb_elevator_request_scheduler;

  logic        clk;
  logic        rst;
  logic [15:0] btn;
  logic [3:0]  cur_floor;
  logic        fire_recall;
  logic [3:0]  floor_req;
  logic [15:0] pending;
  logic        door_open;
  logic        dir_up;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  elevator_request_scheduler #(.DWELL_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn         (btn),
    .cur_floor   (cur_floor),
    .fire_recall (fire_recall),
    .floor_req   (floor_req),
    .pending     (pending),
    .door_open   (door_open),
    .dir_up      (dir_up),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts consecutive door-open samples, bounded so a stuck door cannot hang the run.
  task automatic wait_door(output int cnt);
    cnt = 0;
    while (door_open === 1'b1 && cnt < 20) begin
      cnt++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; btn = '0; cur_floor = 4'd0; fire_recall = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (pending !== 16'h0000) begin n_err++; $display("FAIL rst_pending got=%h exp=%h", pending, 16'h0000); end
    n_cmp++; if (floor_req !== 4'd0) begin n_err++; $display("FAIL rst_floor_req got=%0d exp=%0d", floor_req, 0); end
    n_cmp++; if (door_open !== 1'b0) begin n_err++; $display("FAIL rst_door got=%b exp=%b", door_open, 1'b0); end
    n_cmp++; if (dir_up !== 1'b1) begin n_err++; $display("FAIL rst_dir_up got=%b exp=%b", dir_up, 1'b1); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=%b", busy, 1'b0); end
    tick(); tick();
    rst = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_idle_busy got=%b exp=%b", busy, 1'b0); end
    n_cmp++; if (floor_req !== 4'd0) begin n_err++; $display("FAIL rst_idle_floor got=%0d exp=%0d", floor_req, 0); end
  endtask

  task automatic test_single_call();
    int cnt;
    btn = 16'h0020;
    tick();
    n_cmp++; if (pending !== 16'h0020) begin n_err++; $display("FAIL call_pending got=%h exp=%h", pending, 16'h0020); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL call_busy_k got=%b exp=%b", busy, 1'b0); end
    btn = '0;
    tick();
    n_cmp++; if (floor_req !== 4'd5) begin n_err++; $display("FAIL call_floor_req got=%0d exp=%0d", floor_req, 5); end
    n_cmp++; if (dir_up !== 1'b1) begin n_err++; $display("FAIL call_dir_up got=%b exp=%b", dir_up, 1'b1); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL call_busy got=%b exp=%b", busy, 1'b1); end
    cur_floor = 4'd5;
    tick();
    n_cmp++; if (door_open !== 1'b1) begin n_err++; $display("FAIL call_door_open got=%b exp=%b", door_open, 1'b1); end
    wait_door(cnt);
    n_cmp++; if (cnt !== 4) begin n_err++; $display("FAIL call_dwell got=%0d exp=%0d", cnt, 4); end
    n_cmp++; if (pending !== 16'h0000) begin n_err++; $display("FAIL call_pending_clr got=%h exp=%h", pending, 16'h0000); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL call_idle got=%b exp=%b", busy, 1'b0); end
  endtask

  task automatic test_intermediate();
    int cnt;
    cur_floor = 4'd2;
    tick();
    btn = 16'h0200;
    tick();
    btn = '0;
    tick();
    n_cmp++; if (floor_req !== 4'd9) begin n_err++; $display("FAIL mid_target9 got=%0d exp=%0d", floor_req, 9); end
    cur_floor = 4'd3;
    tick();
    cur_floor = 4'd4; btn = 16'h0040;
    tick();
    n_cmp++; if (pending !== 16'h0240) begin n_err++; $display("FAIL mid_pending got=%h exp=%h", pending, 16'h0240); end
    n_cmp++; if (floor_req !== 4'd9) begin n_err++; $display("FAIL mid_latency got=%0d exp=%0d", floor_req, 9); end
    btn = '0;
    tick();
    n_cmp++; if (floor_req !== 4'd6) begin n_err++; $display("FAIL mid_switch6 got=%0d exp=%0d", floor_req, 6); end
    cur_floor = 4'd5;
    tick();
    cur_floor = 4'd6;
    tick();
    n_cmp++; if (door_open !== 1'b1) begin n_err++; $display("FAIL mid_stop6 got=%b exp=%b", door_open, 1'b1); end
    wait_door(cnt);
    n_cmp++; if (cnt !== 4) begin n_err++; $display("FAIL mid_dwell got=%0d exp=%0d", cnt, 4); end
    n_cmp++; if (floor_req !== 4'd9) begin n_err++; $display("FAIL mid_resume9 got=%0d exp=%0d", floor_req, 9); end
    n_cmp++; if (dir_up !== 1'b1) begin n_err++; $display("FAIL mid_dir_up got=%b exp=%b", dir_up, 1'b1); end
    cur_floor = 4'd9;
    tick();
    wait_door(cnt);
    n_cmp++; if (pending !== 16'h0000 || busy !== 1'b0) begin n_err++; $display("FAIL mid_done got=%h/%b exp=%h/%b", pending, busy, 16'h0000, 1'b0); end
  endtask

  task automatic test_reverse();
    int cnt;
    cur_floor = 4'd7;
    tick();
    btn = 16'h1000;
    tick();
    btn = 16'h0008;
    tick();
    btn = '0;
    n_cmp++; if (pending !== 16'h1008) begin n_err++; $display("FAIL rev_pending got=%h exp=%h", pending, 16'h1008); end
    tick();
    n_cmp++; if (floor_req !== 4'd12 || dir_up !== 1'b1) begin n_err++; $display("FAIL rev_up12 got=%0d/%b exp=%0d/%b", floor_req, dir_up, 12, 1'b1); end
    cur_floor = 4'd12;
    tick();
    wait_door(cnt);
    n_cmp++; if (cnt !== 4) begin n_err++; $display("FAIL rev_dwell got=%0d exp=%0d", cnt, 4); end
    n_cmp++; if (dir_up !== 1'b0) begin n_err++; $display("FAIL rev_dir_dn got=%b exp=%b", dir_up, 1'b0); end
    n_cmp++; if (floor_req !== 4'd3) begin n_err++; $display("FAIL rev_target3 got=%0d exp=%0d", floor_req, 3); end
    cur_floor = 4'd3;
    tick();
    wait_door(cnt);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rev_idle got=%b exp=%b", busy, 1'b0); end
  endtask

  task automatic test_tie();
    int cnt;
    cur_floor = 4'd8;
    tick();
    btn = 16'h0820;
    tick();
    n_cmp++; if (pending !== 16'h0820) begin n_err++; $display("FAIL tie_pending got=%h exp=%h", pending, 16'h0820); end
    btn = '0;
    tick();
    n_cmp++; if (floor_req !== 4'd11 || dir_up !== 1'b1) begin n_err++; $display("FAIL tie_up11 got=%0d/%b exp=%0d/%b", floor_req, dir_up, 11, 1'b1); end
    cur_floor = 4'd11;
    tick();
    wait_door(cnt);
    n_cmp++; if (floor_req !== 4'd5 || dir_up !== 1'b0) begin n_err++; $display("FAIL tie_dn5 got=%0d/%b exp=%0d/%b", floor_req, dir_up, 5, 1'b0); end
    cur_floor = 4'd5;
    tick();
    wait_door(cnt);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL tie_idle got=%b exp=%b", busy, 1'b0); end
  endtask

  task automatic test_door_press();
    int cnt;
    int total;
    cur_floor = 4'd4;
    tick();
    btn = 16'h0010;
    tick();
    btn = '0;
    tick();
    n_cmp++; if (door_open !== 1'b1) begin n_err++; $display("FAIL door_enter got=%b exp=%b", door_open, 1'b1); end
    btn = 16'h0410;
    tick();
    btn = '0;
    n_cmp++; if (pending !== 16'h0400) begin n_err++; $display("FAIL door_discard got=%h exp=%h", pending, 16'h0400); end
    wait_door(cnt);
    total = cnt + 1;
    n_cmp++; if (total !== 4) begin n_err++; $display("FAIL door_dwell got=%0d exp=%0d", total, 4); end
    n_cmp++; if (floor_req !== 4'd10 || dir_up !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL door_next got=%0d/%b/%b exp=%0d/%b/%b", floor_req, dir_up, busy, 10, 1'b1, 1'b1); end
  endtask

  task automatic test_reset_mid_dwell();
    cur_floor = 4'd10;
    tick();
    n_cmp++; if (door_open !== 1'b1) begin n_err++; $display("FAIL mdr_door got=%b exp=%b", door_open, 1'b1); end
    btn = 16'h0F00;
    tick();
    btn = '0;
    n_cmp++; if (pending !== 16'h0B00) begin n_err++; $display("FAIL mdr_pending got=%h exp=%h", pending, 16'h0B00); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (pending !== 16'h0000) begin n_err++; $display("FAIL mdr_async_pending got=%h exp=%h", pending, 16'h0000); end
    n_cmp++; if (floor_req !== 4'd0) begin n_err++; $display("FAIL mdr_async_floor got=%0d exp=%0d", floor_req, 0); end
    n_cmp++; if (door_open !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL mdr_async_door_busy got=%b/%b exp=%b/%b", door_open, busy, 1'b0, 1'b0); end
    n_cmp++; if (dir_up !== 1'b1) begin n_err++; $display("FAIL mdr_async_dir got=%b exp=%b", dir_up, 1'b1); end
    tick();
  endtask

  task automatic test_reset_sync();
    int cnt;
    cur_floor = 4'd2;
    btn = 16'h0020;
    rst = 1'b1;
    tick();
    n_cmp++; if (pending !== 16'h0020 || busy !== 1'b0) begin n_err++; $display("FAIL sync_e1 got=%h/%b exp=%h/%b", pending, busy, 16'h0020, 1'b0); end
    btn = '0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL sync_e2 got=%b exp=%b", busy, 1'b0); end
    tick();
    n_cmp++; if (busy !== 1'b1 || floor_req !== 4'd5) begin n_err++; $display("FAIL sync_e3 got=%b/%0d exp=%b/%0d", busy, floor_req, 1'b1, 5); end
    cur_floor = 4'd5;
    tick();
    wait_door(cnt);
    n_cmp++; if (busy !== 1'b0 || pending !== 16'h0000) begin n_err++; $display("FAIL sync_done got=%b/%h exp=%b/%h", busy, pending, 1'b0, 16'h0000); end
  endtask

`ifdef ELEVATOR_FIRE_RECALL_EN
  task automatic test_fire_recall();
    cur_floor = 4'd9;
    tick();
    btn = 16'h1000;
    tick();
    n_cmp++; if (pending !== 16'h1000) begin n_err++; $display("FAIL fr_pre got=%h exp=%h", pending, 16'h1000); end
    btn = 16'h0002; fire_recall = 1'b1;
    tick();
    btn = '0;
    n_cmp++; if (pending !== 16'h0000 || floor_req !== 4'd0) begin n_err++; $display("FAIL fr_clear got=%h/%0d exp=%h/%0d", pending, floor_req, 16'h0000, 0); end
    n_cmp++; if (busy !== 1'b1 || door_open !== 1'b0) begin n_err++; $display("FAIL fr_down got=%b/%b exp=%b/%b", busy, door_open, 1'b1, 1'b0); end
    tick();
    n_cmp++; if (door_open !== 1'b0 || pending !== 16'h0000) begin n_err++; $display("FAIL fr_travel got=%b/%h exp=%b/%h", door_open, pending, 1'b0, 16'h0000); end
    cur_floor = 4'd0;
    tick();
    n_cmp++; if (door_open !== 1'b1 || busy !== 1'b0 || floor_req !== 4'd0) begin n_err++; $display("FAIL fr_floor0 got=%b/%b/%0d exp=%b/%b/%0d", door_open, busy, floor_req, 1'b1, 1'b0, 0); end
    tick();
    n_cmp++; if (door_open !== 1'b1) begin n_err++; $display("FAIL fr_hold got=%b exp=%b", door_open, 1'b1); end
    fire_recall = 1'b0;
    tick();
    n_cmp++; if (door_open !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL fr_release got=%b/%b exp=%b/%b", door_open, busy, 1'b0, 1'b0); end
  endtask
`else
  task automatic test_recall_ignored();
    int cnt;
    fire_recall = 1'b1;
    btn = 16'h0008;
    tick();
    n_cmp++; if (pending !== 16'h0008) begin n_err++; $display("FAIL fri_pending got=%h exp=%h", pending, 16'h0008); end
    btn = '0;
    tick();
    n_cmp++; if (floor_req !== 4'd3 || dir_up !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL fri_down got=%0d/%b/%b exp=%0d/%b/%b", floor_req, dir_up, busy, 3, 1'b0, 1'b1); end
    fire_recall = 1'b0;
    cur_floor = 4'd3;
    tick();
    wait_door(cnt);
    n_cmp++; if (cnt !== 4 || busy !== 1'b0) begin n_err++; $display("FAIL fri_done got=%0d/%b exp=%0d/%b", cnt, busy, 4, 1'b0); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_call();
    test_intermediate();
    test_reverse();
    test_tie();
    test_door_press();
    test_reset_mid_dwell();
    test_reset_sync();
`ifdef ELEVATOR_FIRE_RECALL_EN
    test_fire_recall();
`else
    test_recall_ignored();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/elevator_request_scheduler.md
ELEVATOR_REQUEST_SCHEDULER -- requirements
Module: elevator_request_scheduler

Interface
REQ-001 Parameter: DWELL_CYCLES, default 4, door-open hold time in clk cycles (range 1..255).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 btn  input  16  call buttons, bit n = floor n; any-width pulse, sampled each clk.
REQ-005 cur_floor  input  4  floor currently reported by the elevator car.
REQ-006 fire_recall  input  1  emergency recall request (see Configuration).
REQ-007 floor_req  output  4  registered target floor driven to the elevator.
REQ-008 pending  output  16  registered latched-request vector.
REQ-009 door_open  output  1  high while in DOOR state.
REQ-010 dir_up  output  1  current travel direction, 1 = up.
REQ-011 busy  output  1  high whenever state != IDLE.

Function
REQ-012 States SHALL be IDLE, UP, DOWN, DOOR; encoding free; state is registered.
REQ-013 Each cycle: pending <= (pending | btn) & ~clr, clr = one-hot of cur_floor when in DOOR, else 0; clear wins over simultaneous press at the same floor.
REQ-014 Request latency: btn bit n high at edge k -> pending[n] high after edge k; floor_req may reflect it after edge k+1.
REQ-015 IDLE: pending[cur_floor] -> DOOR; else any pending above or below -> UP or DOWN toward nearest pending floor, tie -> UP; else stay IDLE with floor_req = cur_floor.
REQ-016 UP: floor_req <= lowest pending floor > cur_floor; when cur_floor == floor_req and that bit pending -> DOOR.
REQ-017 UP with no pending above: pending below -> DOWN, dir_up <= 0; none -> IDLE.
REQ-018 DOWN: symmetric -- floor_req <= highest pending floor < cur_floor; arrival -> DOOR; none below but some above -> UP, dir_up <= 1; none -> IDLE.
REQ-019 Intermediate pending floors SHALL be served on the way: floor_req updates every cycle in UP/DOWN, so a new request between cur_floor and current target becomes the target.
REQ-020 DOOR: door_open = 1, floor_req = cur_floor, dwell counter counts DWELL_CYCLES cycles, then return to UP/DOWN per dir_up evaluation rules (REQ-016..018), or IDLE if pending == 0.
REQ-021 Presses at cur_floor during DOOR are discarded (dwell not extended).
REQ-022 cur_floor change while in DOOR is a protocol error; block SHALL ignore it and finish dwell at the new cur_floor value.
REQ-023 floor_req SHALL never change by more than a registered update per cycle; no combinational path btn -> floor_req.
REQ-024 Floor index arithmetic is 4-bit unsigned; floor 15 up-search and floor 0 down-search return "none", no wrap.

Reset
REQ-025 rst low SHALL immediately force: state IDLE, pending 0, floor_req 0, door_open 0, dir_up 1, busy 0, dwell counter 0.
REQ-026 Reset mid-travel or mid-dwell discards all pending requests; first post-reset edge behaves as IDLE.
REQ-027 Release of rst is synchronised internally (two-flop) before state may leave IDLE.

Configuration
REQ-028 Macro ELEVATOR_FIRE_RECALL_EN defined: fire_recall high SHALL clear pending, block btn, force floor_req 0, state DOWN (IDLE once cur_floor == 0, door_open 1 held while fire_recall high at floor 0).
REQ-029 Macro undefined: fire_recall port present but ignored; no recall logic synthesised.

Verification
REQ-030 Idle at cur_floor 0, pulse btn[5] one cycle -> pending = 0x0020 next edge, floor_req = 5, dir_up 1, busy 1; model cur_floor to 5 -> door_open for 4 cycles, pending 0, IDLE.
REQ-031 Travel up from 2 toward 9, press btn[6] when cur_floor = 4 -> floor_req switches to 6, stop at 6, then resume to 9.
REQ-032 At floor 7 going up with pending = {3,12} -> serve 12 first, then dir_up 0, floor_req 3.
REQ-033 Idle at 8, pending {5,11} pressed same cycle -> tie 3/3 resolves UP, floor_req 11.
REQ-034 During DOOR at floor 4, pulse btn[4] and btn[10] -> pending[4] stays 0, pending[10] set, dwell still exactly 4 cycles.
REQ-035 Assert rst low mid-dwell with pending 0x0F00 -> outputs at reset values asynchronously; with ELEVATOR_FIRE_RECALL_EN, fire_recall at floor 9 -> pending 0, floor_req 0, door_open only after cur_floor = 0.
